// File: rtl/int2float_share_if.sv
// -----------------------------------------------------------------------------
// int2float_share_if
//
// Bundles the per-requester request and response channels of the shared
// int2float scheduler.
//
//   req_valid [NREQ]     operand valid, one bit per requester
//   req_data  [NREQ*11]  operands; requester i owns bits [11*i+10 : 11*i]
//   req_ready [NREQ]     one-hot accept pulse back to the requesters
//   rsp_valid [NREQ]     one-hot result valid
//   rsp_ready [NREQ]     per-requester result accept
//   rsp_data  [7]        result for the lane flagged in rsp_valid
//
// Modports:
//   master - the requesting datapath lanes
//   slave  - the scheduler (int2float_share_ctrl)
// -----------------------------------------------------------------------------
interface int2float_share_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*11-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [6:0]         rsp_data;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/int2float_share_ctrl.sv
// -----------------------------------------------------------------------------
// int2float_share_ctrl
//
// Round-robin scheduler that time-shares one external combinational int2float
// converter (11-bit integer in, 7-bit float code out) among NREQ requesters.
// One operation is in flight at a time:
//   IDLE    arbitrate, accept the winner's operand into op_reg
//   ISSUE   drive op_reg onto conv_in, capture conv_out
//   CAPTURE keep conv_in stable, capture conv_out again (covers a converter
//           that registers its input)
//   RESP    present res_reg to the winner until it accepts
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   CNT_W  width of the completed-operation counter
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       request/response channels (int2float_share_if.slave)
//   conv_in   operand to the shared converter (0 when not converting)
//   conv_out  converter result, combinational from conv_in
//   busy      high whenever an operation is in flight
//   ops_done  count of completed response handshakes (wraps)
//
// Optional feature (macro INT2FLOAT_ZERO_BYPASS_EN):
//   When defined, a zero operand skips the converter and goes straight from
//   IDLE to RESP with a 7'h00 result. When undefined, zero operands take the
//   normal path through the converter.
// -----------------------------------------------------------------------------
module int2float_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    int2float_share_if.slave  bus,
    output logic [10:0]       conv_in,
    input  logic [6:0]        conv_out,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [PTR_W-1:0]   rr_ptr_next;
    logic [PTR_W-1:0]   grant_reg;
    logic [PTR_W-1:0]   grant_next;
    logic [10:0]        op_reg;
    logic [10:0]        op_next;
    logic [6:0]         res_reg;
    logic [6:0]         res_next;
    logic [CNT_W-1:0]   ops_done_reg;
    logic [CNT_W-1:0]   ops_done_next;

    // Arbitration results
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_idx_inc;
    logic [10:0]        win_data;
    int                 cand_i;
    logic [PTR_W-1:0]   cand;

    // Per-lane views
    logic [10:0]        lane_data [NREQ];
    logic [NREQ-1:0]    win_onehot;
    logic [NREQ-1:0]    grant_onehot;

    // -------------------------------------------------------------------------
    // Lane slicing and one-hot decode
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign lane_data[gi]    = bus.req_data[11*gi +: 11];
            assign win_onehot[gi]   = win_found && (win_idx == PTR_W'(gi));
            assign grant_onehot[gi] = (grant_reg == PTR_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbiter: search upward from rr_ptr with wrap-around.
    // The loop runs from the farthest offset down to offset 0 so that the
    // candidate closest to rr_ptr is the last one written and therefore wins.
    // -------------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_i = int'(rr_ptr_reg) + k;
            if (cand_i >= NREQ) begin
                cand_i = cand_i - NREQ;
            end
            cand = PTR_W'(cand_i);
            if (bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Pointer moves to the lane just after the winner (mod NREQ, which need
    // not be a power of two).
    assign win_idx_inc = (win_idx == PTR_W'(NREQ - 1)) ? '0 : (win_idx + PTR_W'(1));
    assign win_data    = lane_data[win_idx];

    // -------------------------------------------------------------------------
    // Next-state and datapath-register logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_next    = grant_reg;
        op_next       = op_reg;
        res_next      = res_reg;
        ops_done_next = ops_done_reg;

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    op_next     = win_data;
                    grant_next  = win_idx;
                    rr_ptr_next = win_idx_inc;
                    state_next  = ISSUE;
`ifdef INT2FLOAT_ZERO_BYPASS_EN
                    // Zero converts to zero; no need to occupy the converter.
                    if (win_data == 11'h000) begin
                        res_next   = 7'h00;
                        state_next = RESP;
                    end
`endif
                end
            end

            ISSUE: begin
                res_next   = conv_out;
                state_next = CAPTURE;
            end

            CAPTURE: begin
                // Second capture picks up the result of a converter that
                // registers its input; for a purely combinational converter it
                // simply re-samples the same value.
                res_next   = conv_out;
                state_next = RESP;
            end

            RESP: begin
                // Only the granted lane's ready completes the handshake.
                if (bus.rsp_ready[grant_reg]) begin
                    ops_done_next = ops_done_reg + CNT_W'(1);
                    state_next    = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            op_reg       <= '0;
            res_reg      <= '0;
            ops_done_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_reg    <= grant_next;
            op_reg       <= op_next;
            res_reg      <= res_next;
            ops_done_reg <= ops_done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Grant is offered only while idle; a completing handshake in RESP never
    // overlaps with a new grant.
    assign bus.req_ready = (state_reg == IDLE) ? win_onehot : '0;
    assign bus.rsp_valid = (state_reg == RESP) ? grant_onehot : '0;
    assign bus.rsp_data  = (state_reg == RESP) ? res_reg : 7'h00;

    // Converter input is parked at zero outside the converting states so the
    // converter logic does not toggle needlessly.
    assign conv_in  = ((state_reg == ISSUE) || (state_reg == CAPTURE)) ? op_reg : 11'h000;
    assign busy     = (state_reg != IDLE);
    assign ops_done = ops_done_reg;

endmodule

// File: tb/tb_int2float_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int2float_share_ctrl
//
// Bench for int2float_share_ctrl (NREQ=4, CNT_W=4). Provides a combinational
// converter model, drives directed scenarios followed by randomized
// requesters, and compares every output on every falling edge against a
// transaction-level model (idle / converting / responding, with an age count
// since acceptance). Honours INT2FLOAT_ZERO_BYPASS_EN for the zero latency.
// -----------------------------------------------------------------------------
module tb_int2float_share_ctrl;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;
`ifdef INT2FLOAT_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [10:0]       conv_in;
    logic [6:0]        conv_out;
    logic              busy;
    logic [CNT_W-1:0]  ops_done;

    int vectors     = 0;
    int miscompares = 0;

    int2float_share_if #(.NREQ(NREQ)) bus ();

    int2float_share_ctrl #(
        .NREQ  (NREQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .conv_in  (conv_in),
        .conv_out (conv_out),
        .busy     (busy),
        .ops_done (ops_done)
    );

    always #5 clk = ~clk;

    // Toy 7-bit float: {exponent+1 (4b), 3 mantissa bits below the MSB}; 0 -> 0.
    function automatic logic [6:0] conv_model(logic [10:0] x);
        int          e;
        logic [10:0] s;
        logic [3:0]  ef;
        if (x == 11'd0) return 7'd0;
        e = 0;
        for (int i = 0; i < 11; i++) if (x[i]) e = i;
        s  = x << (10 - e);
        ef = 4'(e + 1);
        return {ef, s[9:7]};
    endfunction

    assign conv_out = conv_model(conv_in);

    function automatic int rr_pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (p + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model + per-cycle compare (falling edge; inputs are stable
    // from just after the rising edge until the next rising edge).
    // -------------------------------------------------------------------------
    int          m_age   = 0;   // 0 = idle, else cycles since acceptance
    int          m_lat   = 3;
    int          m_lane  = 0;
    int          m_ptr   = 0;
    int          m_count = 0;
    logic [10:0] m_op    = '0;
    bit          m_known = 1'b0;

    always @(negedge clk) begin
        logic [NREQ-1:0] e_rr, e_rv;
        logic [6:0]      e_rd;
        logic [10:0]     e_ci;
        logic            e_busy;
        int              w;
        e_rr = '0; e_rv = '0; e_rd = '0; e_ci = '0; e_busy = 1'b0;
        w = rr_pick(bus.req_valid, m_ptr);
        if (m_age == 0) begin
            if (w >= 0) e_rr = NREQ'(1) << w;
        end else if (m_age < m_lat) begin
            e_ci   = m_op;
            e_busy = 1'b1;
        end else begin
            e_rv   = NREQ'(1) << m_lane;
            e_rd   = conv_model(m_op);
            e_busy = 1'b1;
        end

        if (m_known) begin
            check("req_ready", bus.req_ready, e_rr);
            check("rsp_valid", bus.rsp_valid, e_rv);
            check("rsp_data",  bus.rsp_data,  e_rd);
            check("conv_in",   conv_in,       e_ci);
            check("busy",      busy,          e_busy);
            check("ops_done",  ops_done,      m_count);
        end

        // Advance the model across the coming rising edge.
        if (rst) begin
            m_known = 1'b1;
            m_age   = 0;
            m_ptr   = 0;
            m_count = 0;
        end else if (m_known) begin
            if (m_age == 0) begin
                if (w >= 0) begin
                    m_lane = w;
                    m_op   = bus.req_data[11*w +: 11];
                    m_ptr  = (w + 1) % NREQ;
                    m_lat  = (ZLAT == 1 && m_op == 11'd0) ? 1 : 3;
                    m_age  = 1;
                end
            end else if (m_age < m_lat) begin
                m_age++;
            end else if (bus.rsp_ready[m_lane]) begin
                m_count = (m_count + 1) % (1 << CNT_W);
                $display("txn lane=%0d op=%03h result=%02h ops_done=%0d",
                         m_lane, m_op, conv_model(m_op), m_count);
                m_age = 0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus with literal spot checks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int              g_lane [8];
    int              g_time [8];
    int              ng;
    int              lat;
    logic [NREQ-1:0] got;
    logic [10:0]     d;

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("reset busy",      busy,          0);
        check("reset ops_done",  ops_done,      0);
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset conv_in",   conv_in,       0);

        // Single request on lane 2
        bus.req_data[22 +: 11] = 11'h005;
        bus.req_valid = 4'b0100;
        #1;
        check("single req_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        #1;
        check("single ready drop", bus.req_ready, 0);
        check("single conv_in 1",  conv_in, 11'h005);
        tick(); #1;
        check("single conv_in 2",  conv_in, 11'h005);
        check("single no rsp yet", bus.rsp_valid, 0);
        tick();
        // Back-pressure with lane 0 waiting
        bus.req_data[0 +: 11] = 11'h123;
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '0;
        #1;
        check("single rsp_valid", bus.rsp_valid, 4'b0100);
        check("single rsp_data",  bus.rsp_data, 7'h1A);
        check("single conv idle", conv_in, 0);
        for (int c = 0; c < 10; c++) begin
            tick(); #1;
            check("bp rsp_valid", bus.rsp_valid, 4'b0100);
            check("bp rsp_data",  bus.rsp_data, 7'h1A);
            check("bp busy",      busy, 1);
            check("bp no grant",  bus.req_ready, 0);
        end
        // Ready on the wrong lanes does nothing
        bus.rsp_ready = 4'b1011;
        tick();
        bus.rsp_ready = '0;
        #1;
        check("wrong lane ops_done",  ops_done, 0);
        check("wrong lane rsp_valid", bus.rsp_valid, 4'b0100);
        bus.rsp_ready = 4'b0100;
        #1;
        check("handshake cycle no grant", bus.req_ready, 0);
        tick();
        bus.rsp_ready = '0;
        #1;
        check("after hs ops_done", ops_done, 1);
        check("after hs busy",     busy, 0);
        check("after hs grant0",   bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        tick(); tick();
        bus.rsp_ready = 4'b0001;
        #1;
        check("lane0 rsp_valid", bus.rsp_valid, 4'b0001);
        tick();
        bus.rsp_ready = '0;

        // Reset while lane 1 is in CAPTURE
        bus.req_data[11 +: 11] = 11'h2AA;
        bus.req_valid = 4'b0010;
        #1;
        check("lane1 req_ready", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_data[0 +: 11] = 11'h0F0;
        bus.req_valid = 4'b0011;
        #1;
        check("midrst busy",      busy, 0);
        check("midrst rsp_valid", bus.rsp_valid, 0);
        check("midrst ops_done",  ops_done, 0);
        check("midrst ptr0 wins", bus.req_ready, 4'b0001);

        // Round robin with all lanes requesting and no back-pressure
        bus.req_data[22 +: 11] = 11'h3FF;
        bus.req_data[33 +: 11] = 11'h400;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b1111;
        ng = 0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) begin
                tick(); #1;
            end
            if (bus.req_ready != 0 && ng < 8) begin
                g_lane[ng] = rr_pick(bus.req_ready, 0);
                g_time[ng] = c;
                ng++;
            end
        end
        check("rr grant count", ng, 6);
        for (int k = 0; k < 6 && k < ng; k++) begin
            check("rr grant lane", g_lane[k], k % NREQ);
            check("rr grant time", g_time[k], 4 * k);
        end
        bus.req_valid = '0;
        tick();   // sixth completion -> ops_done = 6

        // Ten more single operations to wrap the 4-bit counter; first is zero.
        for (int k = 0; k < 10; k++) begin
            if (k == 9) check("ops_done before wrap", ops_done, 15);
            d = (k == 0) ? 11'h000 : 11'(k * 37 + 1);
            bus.req_data[11*(k%NREQ) +: 11] = d;
            bus.req_valid = NREQ'(1) << (k % NREQ);
            #1;
            check("wrap req_ready", bus.req_ready, NREQ'(1) << (k % NREQ));
            tick();
            bus.req_valid = '0;
            #1;
            lat = 1;
            while (bus.rsp_valid == 0 && lat < 8) begin
                tick(); #1;
                lat++;
            end
            check("latency", lat, (k == 0) ? ZLAT : 3);
            if (k == 0) check("zero rsp_data", bus.rsp_data, 7'h00);
            tick();
        end
        #1;
        check("ops_done wrapped", ops_done, 0);

        // Randomized requesters against the model
        got = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && got[i]) begin
                    bus.req_valid[i] = 1'b0;
                end else if (bus.req_valid[i] && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    d = ($urandom_range(0, 7) == 0) ? 11'h000 : 11'($urandom);
                    bus.req_data[11*i +: 11] = d;
                    bus.req_valid[i] = 1'b1;
                end
            end
            bus.rsp_ready = NREQ'($urandom);
            #1;
            got = bus.req_ready;
        end
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
